div113_seq_ctrl: RTL

//  Sequential controller that computes the quotient and remainder of a 48-bit unsigned dividend divided by constant 113.

---
 rtl/div113_seq_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/div113_seq_ctrl.sv
// div113_seq_ctrl
//   Sequential divide-by-constant controller: 48-bit unsigned dividend / 113.
//   The dividend is consumed MSB-first as DIG_W-bit digits, one digit per
//   clock.  Each step applies the chunk function
//   {rem, digit} -> {qdig, rem'}, so the running remainder stays below DIVISOR.
//   Valid/ready handshakes on the operand and result sides; one operation in
//   flight at a time (IDLE -> RUN -> DONE -> IDLE).
//
//   Build option: define DIV113_LZ_SKIP_EN to skip the leading all-zero
//   digits of the dividend at accept time.  The results are identical.
//   Only the number of RUN cycles changes (16 - lz, minimum 1).  Without the
//   macro the controller always runs 16 steps and has no leading-zero logic.
module div113_seq_ctrl #(
    parameter int WIDTH   = 48,
    parameter int DIG_W   = 3,
    parameter int DIVISOR = 113,
    parameter int REM_W   = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [REM_W-1:0] out_rem,
    output logic             busy
);

    localparam int NDIG  = WIDTH / DIG_W;
    localparam int CNT_W = $clog2(NDIG);
    localparam int T_W   = REM_W + DIG_W;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NDIG - 1);
    localparam logic [T_W-1:0]   DIV_T     = T_W'(DIVISOR);
    localparam logic [REM_W-1:0] DIV_R     = REM_W'(DIVISOR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_quot;
    logic [REM_W-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [DIG_W-1:0] w_digit;
    logic [T_W-1:0]   w_chunk;
    logic [DIG_W-1:0] w_qdig;
    logic [REM_W-1:0] w_rem_nxt;
    logic             w_accept;
    logic [WIDTH-1:0] w_load_shift;
    logic [CNT_W-1:0] w_load_cnt;

    // One restoring-division digit step.  The input t = rem*2^DIG_W + digit
    // is below DIVISOR*2^DIG_W, so the quotient digit fits in DIG_W bits.
    // The digit is resolved bit by bit by subtracting DIVISOR shifted left by b.
    function automatic logic [T_W-1:0] f_chunk(
        input logic [REM_W-1:0] rem,
        input logic [DIG_W-1:0] dig
    );
        logic [T_W-1:0]   t;
        logic [DIG_W-1:0] q;
        t = {rem, dig};
        q = '0;
        for (int b = DIG_W - 1; b >= 0; b--) begin
            if (t >= (DIV_T << b)) begin
                t    = t - (DIV_T << b);
                q[b] = 1'b1;
            end
        end
        return {q, t[REM_W-1:0]};
    endfunction

`ifdef DIV113_LZ_SKIP_EN
    // Count the all-zero digits at the top of the dividend, capped at NDIG-1.
    // The cap ensures that at least one step always runs.
    function automatic logic [CNT_W-1:0] f_lead_zero_digits(
        input logic [WIDTH-1:0] d
    );
        logic [CNT_W-1:0] n;
        logic             hit;
        n   = '0;
        hit = 1'b0;
        for (int i = 0; i < NDIG - 1; i++) begin
            if (!hit && (d[WIDTH-1-DIG_W*i -: DIG_W] == '0)) begin
                n = n + 1'b1;
            end else begin
                hit = 1'b1;
            end
        end
        return n;
    endfunction

    logic [CNT_W-1:0] w_lz;

    // Leading zero digits contribute quotient digit 0 with remainder 0.
    // Starting the step counter at lz therefore yields the same final result.
    assign w_lz         = f_lead_zero_digits(in_dividend);
    assign w_load_shift = in_dividend << (DIG_W * int'(w_lz));
    assign w_load_cnt   = w_lz;
`else
    assign w_load_shift = in_dividend;
    assign w_load_cnt   = '0;
`endif

    assign w_digit   = r_shift[WIDTH-1 -: DIG_W];
    assign w_chunk   = f_chunk(r_rem, w_digit);
    assign w_qdig    = w_chunk[T_W-1 -: DIG_W];
    assign w_rem_nxt = w_chunk[REM_W-1:0];

    // in_ready is a register, so in_valid never reaches in_ready combinationally.
    assign w_accept  = r_in_ready && in_valid;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_quot  = r_quot;
    assign out_rem   = r_rem;
    assign busy      = r_busy;

    // Control FSM with registered handshake/status outputs and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_quot     <= '0;
                        r_rem      <= '0;
                        r_cnt      <= w_load_cnt;
                    end
                end
                S_RUN: begin
                    r_quot <= {r_quot[WIDTH-DIG_W-1:0], w_qdig};
                    r_rem  <= w_rem_nxt;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    // Result is held until the consumer takes it.
                    if (r_out_valid && out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Dividend shift register: load at accept, advance one digit per RUN cycle.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shift <= w_load_shift;
        end else if (r_state == S_RUN) begin
            r_shift <= r_shift << DIG_W;
        end
    end

    // The running remainder must always be a valid residue modulo DIVISOR.
    a_rem_range: assert property (@(posedge clk) disable iff (!rst_n)
        (r_rem < DIV_R));

endmodule
